serial_subtractor_32_bit: RTL
=============================

Name: serial_subtractor_32_bit

Overview:
- Multi-cycle subtractor computing Z = A - B as A + ~B + 1.
- Processes DIGIT bits per clock through a carry-chain slice, with a registered carry between digits.
- Companion to the combinational ripple adder. Used where area matters more than latency, e.g. the ALU slow path.
- start/busy/done handshake. Produces carry/borrow, signed overflow, zero and negative flags.

Parameters:
- N, 32: operand and result width.
- DIGIT, 1: bits processed per cycle. Must divide N; N/DIGIT ≥ 2. A non-dividing value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only while busy=0
- A  input  N  minuend; sampled on the accepted start edge only
- B  input  N  subtrahend; sampled on the accepted start edge only
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when the result is valid
- Z  output  N  result A-B mod 2^N; held until next completion
- Cout  output  1  carry out of the MSB; 1 = no borrow (A ≥ B unsigned)
- V  output  1  signed overflow: (A[N-1] != B[N-1]) && (Z[N-1] != A[N-1])
- Zero  output  1  Z == 0
- Neg  output  1  Z[N-1]

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset (rst=1 at an edge): FSM goes to IDLE. busy=0, done=0, Z=0, Cout=0, V=0, Zero=1, Neg=0. Internal operand, carry and digit-counter registers are cleared. rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E:
  - Latch A into the working register, ~B into the subtrahend register, and carry=1. Set digit counter k=0.
  - Go to RUN; busy=1 after E.
- RUN, each edge:
  - Add digit k: bits [k*DIGIT +: DIGIT] of A and ~B plus carry. Write the sum bits into the shadow result register and the carry-out into the carry register. Increment k.
  - After the edge that processes digit N/DIGIT-1, go to DONE.
- Entering DONE:
  - Copy the shadow result to Z. Cout = final carry. Compute V, Zero and Neg from the latched operand MSBs and the final Z.
  - done=1 and busy=0 for exactly the cycle following that edge.
- Latency: the accepted start at edge E gives done=1 in the cycle after edge E+N/DIGIT.
- DONE, next edge:
  - start=1: accept a new operation (back-to-back; no idle cycle required).
  - Otherwise go to IDLE.
  - done is never high for two consecutive cycles.
- start while busy=1 is ignored. The operation in flight is unaffected. A and B are don't-care while busy.
- Z, Cout, V, Zero and Neg change only on the completion edge or on reset. They hold their last values through IDLE and during a subsequent RUN.
- rst during RUN: the operation is abandoned, reset values apply, no done pulse.
- Arithmetic is modulo 2^N with no saturation. The shadow register is N bits and the carry is 1 bit.

Test Plan:
- N=32, DIGIT=1, start with A=5, B=3 at edge 0 -> busy=1 for cycles 1-32; done=1 only in cycle 33 (after edge 32); Z=0x00000002, Cout=1, V=0, Zero=0, Neg=0.
- A=3, B=5 -> Z=0xFFFFFFFE, Cout=0, Neg=1, V=0, Zero=0.
- A=0x80000000, B=1 -> Z=0x7FFFFFFF, V=1, Cout=1, Neg=0. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> Z=0x80000000, V=1, Cout=0.
- A=7, B=7 -> Z=0, Zero=1, Cout=1. Then restart in the done cycle with A=10, B=4 -> no gap, done exactly 32 cycles later, Z=6; Z holds 0 until then.
- Start A=100, B=1; pulse start with A=0, B=0 at cycle 5 -> ignored, Z=99. Second run: assert rst at cycle 10 -> busy=0 next cycle, no done, Z=0, Zero=1.
- Instance with DIGIT=4: A=0x12345678, B=0x11111111 -> done exactly 8 cycles after start, Z=0x01234567, Cout=1.

Source files
------------

// File: rtl/serial_subtractor_32_bit_if.sv
`default_nettype none
// ============================================================================
// serial_subtractor_32_bit_if
// Handshake, operand and result/flag bundle for the serial subtractor.
// Revision: 1.0
// ============================================================================
interface serial_subtractor_32_bit_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Z;
    logic         Cout;
    logic         V;
    logic         Zero;
    logic         Neg;

    modport master (
        output start, A, B,
        input  busy, done, Z, Cout, V, Zero, Neg
    );

    modport slave (
        input  start, A, B,
        output busy, done, Z, Cout, V, Zero, Neg
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_32_bit.sv
`default_nettype none
// ============================================================================
// serial_subtractor_32_bit
// Multi-cycle Z = A + ~B + 1, DIGIT bits per clock with a registered carry.
// Revision: 1.0
// ============================================================================
module serial_subtractor_32_bit #(
    parameter int N     = 32,
    parameter int DIGIT = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_subtractor_32_bit_if.slave bus
);
    localparam int NUM_DIGITS = N / DIGIT;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if ((N % DIGIT) != 0 || NUM_DIGITS < 2) begin : g_bad_digit
        $error("DIGIT must divide N with at least two digits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_inv_q, b_inv_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [N-1:0]    z_q, z_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   k_q, k_d;
    logic            cout_q, cout_d;
    logic            v_q, v_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;

    int              w_base;
    logic [DIGIT:0]  w_sum;
    logic [N-1:0]    w_result;
    logic            w_last;

    always_comb begin
        w_base   = int'(k_q) * DIGIT;
        w_sum    = {1'b0, a_q[w_base +: DIGIT]} + {1'b0, b_inv_q[w_base +: DIGIT]}
                 + {{DIGIT{1'b0}}, carry_q};
        // Shadow with the current digit merged in, so Z can be loaded on the same edge.
        w_result = shadow_q;
        w_result[w_base +: DIGIT] = w_sum[DIGIT-1:0];
        w_last   = (k_q == CW'(NUM_DIGITS - 1));

        state_d  = state_q;
        a_d      = a_q;
        b_inv_d  = b_inv_q;
        shadow_d = shadow_q;
        carry_d  = carry_q;
        k_d      = k_q;
        z_d      = z_q;
        cout_d   = cout_q;
        v_d      = v_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_inv_d  = ~bus.B;
                    carry_d  = 1'b1;
                    k_d      = '0;
                    shadow_d = '0;
                    state_d  = RUN;
                end else if (state_q == DONE) begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                shadow_d = w_result;
                carry_d  = w_sum[DIGIT];
                k_d      = k_q + CW'(1);
                if (w_last) begin
                    k_d     = '0;
                    state_d = DONE;
                    z_d     = w_result;
                    cout_d  = w_sum[DIGIT];
                    // Operand signs differ iff A's MSB equals the inverted-B MSB.
                    v_d     = (a_q[N-1] == b_inv_q[N-1]) && (w_result[N-1] != a_q[N-1]);
                    zero_d  = (w_result == '0);
                    neg_d   = w_result[N-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_inv_q  <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            z_q      <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_inv_q  <= b_inv_d;
            shadow_q <= shadow_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            z_q      <= z_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Z    = z_q;
    assign bus.Cout = cout_q;
    assign bus.V    = v_q;
    assign bus.Zero = zero_q;
    assign bus.Neg  = neg_q;
endmodule
`default_nettype wire
